// File: rtl/ysyx_23060184_axi_lsu_pkg.sv
// Shared types and constants for the AXI load/store unit: FSM states,
// access-size codes, AXI response codes and the alignment check.
package ysyx_23060184_axi_lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR,
    ST_WR_RESP,
    ST_RESP
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // A dword access is only meaningful on a 64-bit bus.
  function automatic logic misaligned(input logic [2:0] lo, input logic [1:0] size,
                                      input int data_w);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lo[0];
      SZ_W:    return |lo[1:0];
      default: return (data_w != 64) || (|lo);
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060184_lsu_align.sv
// Byte-lane steering: store data/strobe placement and load extraction
// with sign or zero extension.
module ysyx_23060184_lsu_align
  import ysyx_23060184_axi_lsu_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [OFF_W-1:0]    offset,
  input  logic [1:0]          size,
  input  logic                is_unsigned,
  input  logic [DATA_W-1:0]   store_data,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   rdata,
  output logic [DATA_W-1:0]   load_data
);

  logic [DATA_W/8-1:0] mask;
  logic [DATA_W-1:0]   shifted;
  logic                sign;

  for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_mask
    assign mask[gi] = (gi < (1 << size));
  end

  assign wstrb   = mask << offset;
  assign wdata   = store_data << {offset, 3'b000};
  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    sign = 1'b0;
    case (size)
      SZ_B:    sign = shifted[7];
      SZ_H:    sign = shifted[15];
      SZ_W:    sign = shifted[31];
      default: sign = shifted[DATA_W-1];
    endcase
    sign = sign & ~is_unsigned;
  end

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_ext
    assign load_data[gi] = (gi < (8 << size)) ? shifted[gi] : sign;
  end

endmodule

// File: rtl/ysyx_23060184_axi_lsu.sv
// Single-outstanding load/store unit bridging a simple request port to AXI.
// All handshake and response outputs come straight from flops.
module ysyx_23060184_axi_lsu
  import ysyx_23060184_axi_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int OFF_W = $clog2(DATA_W / 8);

  lsu_state_e        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              aw_done_reg, aw_done_next, w_done_reg, w_done_next;
  logic              req_ready_reg, arvalid_reg, rready_reg, awvalid_reg, wvalid_reg, bready_reg;
  logic              rsp_valid_reg, rsp_err_reg, rsp_err_next;
  logic [DATA_W-1:0] rsp_data_reg, rsp_data_next, load_data;
  logic              accept, fault, ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic              unused_resp;

  assign accept = req_valid & req_ready_reg;
  assign fault  = misaligned(req_addr[2:0], req_size, DATA_W);
  assign ar_hs  = arvalid_reg & arready;
  assign r_hs   = rready_reg & rvalid;
  assign aw_hs  = awvalid_reg & awready;
  assign w_hs   = wvalid_reg & wready;
  assign b_hs   = bready_reg & bvalid;
  assign unused_resp = ^{rresp[0], bresp[0]};

  always_comb begin
    state_next    = state_reg;
    aw_done_next  = 1'b0;
    w_done_next   = 1'b0;
    rsp_err_next  = rsp_err_reg;
    rsp_data_next = rsp_data_reg;
    case (state_reg)
      ST_IDLE:
        if (accept) begin
          if (fault) begin
            state_next    = ST_RESP;
            rsp_err_next  = 1'b1;
            rsp_data_next = '0;
          end else begin
            state_next = req_we ? ST_WR : ST_RD_ADDR;
          end
        end
      ST_RD_ADDR: if (ar_hs) state_next = ST_RD_DATA;
      ST_RD_DATA:
        if (r_hs) begin
          state_next    = ST_RESP;
          rsp_err_next  = rresp[1];
          rsp_data_next = load_data;
        end
      ST_WR: begin
        // Address and data channels complete independently, in either order.
        aw_done_next = aw_done_reg | aw_hs;
        w_done_next  = w_done_reg | w_hs;
        if (aw_done_next && w_done_next) state_next = ST_WR_RESP;
      end
      ST_WR_RESP:
        if (b_hs) begin
          state_next    = ST_RESP;
          rsp_err_next  = bresp[1];
          rsp_data_next = '0;
        end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      req_ready_reg <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_data_reg  <= '0;
      addr_reg      <= '0;
      size_reg      <= SZ_B;
      uns_reg       <= 1'b0;
      wdata_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      aw_done_reg   <= aw_done_next;
      w_done_reg    <= w_done_next;
      // Outputs are registered decodes of the next state.
      req_ready_reg <= (state_next == ST_IDLE);
      arvalid_reg   <= (state_next == ST_RD_ADDR);
      rready_reg    <= (state_next == ST_RD_DATA);
      awvalid_reg   <= (state_next == ST_WR) && !aw_done_next;
      wvalid_reg    <= (state_next == ST_WR) && !w_done_next;
      bready_reg    <= (state_next == ST_WR_RESP);
      rsp_valid_reg <= (state_next == ST_RESP);
      rsp_err_reg   <= rsp_err_next;
      rsp_data_reg  <= rsp_data_next;
      if (accept) begin
        addr_reg  <= req_addr;
        size_reg  <= req_size;
        uns_reg   <= req_unsigned;
        wdata_reg <= req_wdata;
      end
    end
  end

  ysyx_23060184_lsu_align #(.DATA_W(DATA_W)) u_align (
    .offset      (addr_reg[OFF_W-1:0]),
    .size        (size_reg),
    .is_unsigned (uns_reg),
    .store_data  (wdata_reg),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .rdata       (rdata),
    .load_data   (load_data)
  );

  assign araddr    = {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign awaddr    = {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign req_ready = req_ready_reg;
  assign arvalid   = arvalid_reg;
  assign rready    = rready_reg;
  assign awvalid   = awvalid_reg;
  assign wvalid    = wvalid_reg;
  assign wlast     = wvalid_reg;
  assign bready    = bready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_ysyx_23060184_axi_lsu.sv
// Directed bench for the AXI LSU: loads, stores, faults, error responses
// and asynchronous reset mid-transaction.
module tb_ysyx_23060184_axi_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic        arvalid, arready, rvalid, rready, awvalid, awready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready, bvalid, bready;

  int n_cmp = 0;
  int n_mis = 0;
  int lat;
  int b_cnt, r_cnt;
  logic [31:0] rsp_seen;

  always #5 clk = ~clk;

  ysyx_23060184_axi_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a request on a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    check("req_ready", 64'(req_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Latency in clock edges from acceptance to rsp_valid being visible.
  task automatic wait_rsp(output int l);
    l = 1;
    while (!rsp_valid && l < 20) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = '0;
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;

    repeat (2) @(negedge clk);
    check("reset req_ready", 64'(req_ready), 64'(0));
    check("reset rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset rsp_data", 64'(rsp_data), 64'(0));
    check("reset valids", 64'({arvalid, rready, awvalid, wvalid, wlast, bready}), 64'(0));
    rst = 1'b0;

    // lw, ready slave
    issue(1'b0, 32'h8000_0004, 2'd2, 1'b0, 32'h0);
    check("lw arvalid", 64'(arvalid), 64'(1));
    check("lw araddr", 64'(araddr), 64'(32'h8000_0004));
    wait_rsp(lat);
    check("lw latency", 64'(lat), 64'(3));
    check("lw rsp_data", 64'(rsp_data), 64'(32'hDEAD_BEEF));
    check("lw rsp_err", 64'(rsp_err), 64'(0));
    @(negedge clk);
    check("lw rsp_valid pulse", 64'(rsp_valid), 64'(0));
    $display("txn lw  0x80000004 -> data %h err %0d lat %0d", rsp_data, rsp_err, lat);

    // lb / lbu from the top byte lane
    rdata = 32'h8012_3456;
    issue(1'b0, 32'h8000_0003, 2'd0, 1'b0, 32'h0);
    check("lb araddr", 64'(araddr), 64'(32'h8000_0000));
    wait_rsp(lat);
    check("lb latency", 64'(lat), 64'(3));
    check("lb rsp_data", 64'(rsp_data), 64'(32'hFFFF_FF80));
    $display("txn lb  0x80000003 -> data %h", rsp_data);
    issue(1'b0, 32'h8000_0003, 2'd0, 1'b1, 32'h0);
    wait_rsp(lat);
    check("lbu rsp_data", 64'(rsp_data), 64'(32'h0000_0080));
    $display("txn lbu 0x80000003 -> data %h", rsp_data);

    // lh signed from upper half
    rdata = 32'h8001_1234;
    issue(1'b0, 32'h8000_0002, 2'd1, 1'b0, 32'h0);
    wait_rsp(lat);
    check("lh rsp_data", 64'(rsp_data), 64'(32'hFFFF_8001));
    $display("txn lh  0x80000002 -> data %h", rsp_data);

    // sw, both channels complete in the same cycle
    issue(1'b1, 32'h8000_0008, 2'd2, 1'b0, 32'h1122_3344);
    check("sw awvalid", 64'(awvalid), 64'(1));
    check("sw wvalid", 64'(wvalid), 64'(1));
    check("sw wlast", 64'(wlast), 64'(1));
    check("sw wstrb", 64'(wstrb), 64'(4'b1111));
    check("sw wdata", 64'(wdata), 64'(32'h1122_3344));
    check("sw awaddr", 64'(awaddr), 64'(32'h8000_0008));
    wait_rsp(lat);
    check("sw latency", 64'(lat), 64'(3));
    check("sw rsp_data", 64'(rsp_data), 64'(0));
    check("sw rsp_err", 64'(rsp_err), 64'(0));
    $display("txn sw  0x80000008 -> err %0d lat %0d", rsp_err, lat);

    // sb into byte lane 1
    issue(1'b1, 32'h8000_0001, 2'd0, 1'b0, 32'h0000_00AB);
    check("sb wstrb", 64'(wstrb), 64'(4'b0010));
    check("sb wdata", 64'(wdata), 64'(32'h0000_AB00));
    wait_rsp(lat);
    check("sb latency", 64'(lat), 64'(3));
    $display("txn sb  0x80000001 -> err %0d lat %0d", rsp_err, lat);

    // sh with awready three cycles ahead of wready
    wready = 1'b0;
    issue(1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'hABCD_1234);
    check("sh wstrb", 64'(wstrb), 64'(4'b1100));
    check("sh wdata", 64'(wdata), 64'(32'h1234_0000));
    b_cnt = 0; r_cnt = 0; rsp_seen = 32'hFFFF_FFFF;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("sh awvalid dropped", 64'(awvalid), 64'(0));
        check("sh wvalid held", 64'(wvalid), 64'(1));
      end
      if (i == 3) begin
        check("sh no B before W", 64'(bready), 64'(0));
        wready = 1'b1;
      end
      if (bvalid && bready) b_cnt++;
      if (rsp_valid) begin
        r_cnt++;
        rsp_seen = rsp_data;
      end
    end
    check("sh B count", 64'(b_cnt), 64'(1));
    check("sh rsp count", 64'(r_cnt), 64'(1));
    check("sh rsp_data", 64'(rsp_seen), 64'(0));
    $display("txn sh  0x80000002 -> B %0d rsp %0d", b_cnt, r_cnt);

    // misaligned lw: fault with no bus traffic
    issue(1'b0, 32'h8000_0001, 2'd2, 1'b0, 32'h0);
    check("mis arvalid", 64'(arvalid), 64'(0));
    wait_rsp(lat);
    check("mis latency", 64'(lat), 64'(1));
    check("mis rsp_err", 64'(rsp_err), 64'(1));
    $display("txn lw  0x80000001 -> err %0d lat %0d", rsp_err, lat);

    // dword on a 32-bit bus: fault
    issue(1'b1, 32'h8000_0000, 2'd3, 1'b0, 32'h0);
    check("ld awvalid", 64'(awvalid), 64'(0));
    wait_rsp(lat);
    check("ld latency", 64'(lat), 64'(1));
    check("ld rsp_err", 64'(rsp_err), 64'(1));
    $display("txn sd  0x80000000 -> err %0d lat %0d", rsp_err, lat);

    // SLVERR on read data
    rresp = 2'b10;
    issue(1'b0, 32'h8000_0010, 2'd2, 1'b0, 32'h0);
    wait_rsp(lat);
    check("slverr latency", 64'(lat), 64'(3));
    check("slverr rsp_err", 64'(rsp_err), 64'(1));
    $display("txn lw  0x80000010 rresp=2 -> err %0d", rsp_err);
    rresp = 2'b00;

    // asynchronous reset while waiting in RD_DATA
    rvalid = 1'b0;
    issue(1'b0, 32'h8000_0020, 2'd2, 1'b0, 32'h0);
    @(negedge clk);
    check("rst pre rready", 64'(rready), 64'(1));
    #1 rst = 1'b1;
    #1;
    check("rst rready", 64'(rready), 64'(0));
    check("rst req_ready", 64'(req_ready), 64'(0));
    check("rst rsp_valid", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    rvalid = 1'b1;
    @(negedge clk);
    check("post-rst req_ready", 64'(req_ready), 64'(1));
    check("post-rst rready", 64'(rready), 64'(0));
    $display("txn lw  0x80000020 reset in RD_DATA -> req_ready %0d", req_ready);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
